// File: rtl/poly_addsub_stream.sv
// rtl/poly_addsub_stream.sv - streaming pointwise add/sub of ML-KEM polynomials mod Q=3329
// One output register with back-to-back throughput; frames of N coefficient pairs.

module mod_add (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] c
);
  localparam logic [12:0] QW = 13'd3329;

  logic [12:0] s;

  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    c = (s >= QW) ? 12'(s - QW) : s[11:0];
  end
endmodule

module poly_addsub_stream #(
  parameter int N     = 256,
  parameter int CNT_W = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        sub_i,
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [11:0] c_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        range_err_o
);
  localparam logic [11:0]      Q       = 12'd3329;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic             sub_q;
  logic [11:0]      b_neg, b_eff, sum;
  logic             start_ok, in_acc, out_acc, in_last;

  // Zero must map to zero, otherwise Q - 0 would leave the range [0, Q-1].
  assign b_neg = (b_i == 12'd0) ? 12'd0 : Q - b_i;
  assign b_eff = sub_q ? b_neg : b_i;

  mod_add u_mod_add (
    .a (a_i),
    .b (b_eff),
    .c (sum)
  );

  assign ready_o  = (state == S_RUN) && (!valid_o || ready_i);
  assign in_acc   = valid_i && ready_o;
  assign out_acc  = valid_o && ready_i;
  assign in_last  = (in_cnt == CNT_MAX);
  assign start_ok = (state == S_IDLE) && start_i;
  assign busy_o   = (state != S_IDLE);
  assign done_o   = (state == S_DONE);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_i) state_n = S_RUN;
      S_RUN:   if (in_acc && in_last) state_n = S_DRAIN;
      S_DRAIN: if (out_acc && last_o) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      sub_q       <= 1'b0;
      valid_o     <= 1'b0;
      c_o         <= 12'd0;
      last_o      <= 1'b0;
      range_err_o <= 1'b0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        sub_q       <= sub_i;
        in_cnt      <= '0;
        out_cnt     <= '0;
        range_err_o <= 1'b0;
      end
      // A new accept overrides the drain so the register never bubbles.
      if (in_acc) begin
        in_cnt  <= in_last ? '0 : in_cnt + CNT_W'(1);
        c_o     <= sum;
        last_o  <= in_last;
        valid_o <= 1'b1;
        if (a_i >= Q || b_i >= Q) range_err_o <= 1'b1;
      end else if (out_acc) begin
        valid_o <= 1'b0;
        last_o  <= 1'b0;
      end
      if (out_acc) out_cnt <= (out_cnt == CNT_MAX) ? '0 : out_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_poly_addsub_stream.sv
// tb/tb_poly_addsub_stream.sv - bench for poly_addsub_stream
// Golden (a +/- b) mod Q queue model with a per-cycle compare process.

module tb_poly_addsub_stream;
  localparam int N = 256;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, sub_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic [11:0] a_i = 12'd0, b_i = 12'd0;
  logic        ready_o, valid_o, last_o, busy_o, done_o, range_err_o;
  logic [11:0] c_o;

  int total = 0;
  int bad = 0;

  int a_arr[N];
  int b_arr[N];
  int log_c[N];

  poly_addsub_stream #(.N(N)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .sub_i(sub_i),
    .a_i(a_i), .b_i(b_i), .valid_i(valid_i), .ready_o(ready_o),
    .c_o(c_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o), .range_err_o(range_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int golden(input int a, input int b, input bit sub);
    int bp, s;
    if (a < Q && b < Q) return sub ? (a - b + Q) % Q : (a + b) % Q;
    // Out-of-range operands pass through the same add-with-one-correction rule.
    bp = sub ? ((b == 0) ? 0 : ((Q - b) & 4095)) : b;
    s = a + bp;
    if (s >= Q) s = s - Q;
    return s & 4095;
  endfunction

  int q_exp[$];
  int beats = 0;
  bit exp_rerr = 0, last_taken = 0, stalled = 0, post_rst = 0, cur_sub = 0;
  logic [11:0] hold_c;
  logic        hold_l;

  always @(negedge clk) begin
    if (post_rst) begin
      check("rst_valid_o", valid_o, 0);
      check("rst_c_o", c_o, 0);
      check("rst_last_o", last_o, 0);
      check("rst_done_o", done_o, 0);
      check("rst_range_err", range_err_o, 0);
      check("rst_busy_o", busy_o, 0);
      check("rst_ready_o", ready_o, 0);
      post_rst = 0;
    end
    if (rst) begin
      q_exp.delete();
      beats = 0; exp_rerr = 0; last_taken = 0; stalled = 0; post_rst = 1;
    end else begin
      check("done_timing", done_o, last_taken);
      if (done_o) check("beats_per_frame", beats, N);
      check("range_err", range_err_o, exp_rerr);
      if (stalled) begin
        check("stall_valid", valid_o, 1);
        check("stall_c", c_o, hold_c);
        check("stall_last", last_o, hold_l);
      end
      if (valid_o && !ready_i) check("stall_ready_o", ready_o, 0);
      last_taken = 0;
      if (valid_o && ready_i) begin
        if (q_exp.size() == 0) check("beat_without_input", 1, 0);
        else begin
          check("c_o", c_o, q_exp.pop_front());
          check("last_o", last_o, (beats == N - 1));
          if (beats < N) log_c[beats] = c_o;
          beats++;
          last_taken = last_o;
        end
      end
      stalled = valid_o && !ready_i;
      hold_c = c_o;
      hold_l = last_o;
      if (start_i && !busy_o) begin
        exp_rerr = 0; beats = 0; cur_sub = sub_i;
      end
      if (valid_i && ready_o) begin
        q_exp.push_back(golden(a_i, b_i, cur_sub));
        if (a_i >= 12'(Q) || b_i >= 12'(Q)) exp_rerr = 1;
      end
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = $urandom_range(Q - 1);
      b_arr[i] = $urandom_range(Q - 1);
    end
  endtask

  task automatic run_frame(input bit sub, input int vpct, input int rpct,
                           input int stall_at, input int restart_at, input int abort_at);
    int idx, cyc, stall_cnt;
    bit got;
    @(posedge clk); #1;
    start_i = 1; sub_i = sub; ready_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    idx = 0; cyc = 0; stall_cnt = 0;
    while (idx < N && cyc < 20000) begin
      valid_i = ($urandom_range(99) < vpct);
      a_i = 12'(a_arr[idx]);
      b_i = 12'(b_arr[idx]);
      if (idx == stall_at && stall_cnt < 5) begin
        ready_i = 0; stall_cnt++;
      end else ready_i = ($urandom_range(99) < rpct);
      start_i = (idx == restart_at);
      if (idx == abort_at) begin
        rst = 1; valid_i = 0; start_i = 0;
        @(posedge clk); #1;
        rst = 0; ready_i = 1;
        return;
      end
      @(negedge clk);
      if (valid_i && ready_o) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    valid_i = 0; start_i = 0;
    if (cyc >= 20000) check("input_timeout", idx, N);
    got = 0;
    for (int k = 0; k < 2000 && !got; k++) begin
      ready_i = ($urandom_range(99) < rpct) || (k > 20);
      @(negedge clk);
      if (done_o) got = 1;
      @(posedge clk); #1;
    end
    check("done_seen", got, 1);
    @(negedge clk);
    check("busy_after_done", busy_o, 0);
    ready_i = 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;

    check("pin_add_10_20", golden(10, 20, 0), 30);
    check("pin_add_3328_1", golden(3328, 1, 0), 0);
    check("pin_add_3000_3000", golden(3000, 3000, 0), 2671);
    check("pin_sub_5_7", golden(5, 7, 1), 3327);
    check("pin_sub_0_3328", golden(0, 3328, 1), 1);
    check("pin_oor_3329_5", golden(3329, 5, 0), 5);

    // T1 add
    fill_rand();
    a_arr[0] = 10;   b_arr[0] = 20;
    a_arr[1] = 3328; b_arr[1] = 1;
    a_arr[2] = 3000; b_arr[2] = 3000;
    a_arr[3] = 3328; b_arr[3] = 3328;
    run_frame(0, 100, 100, -1, -1, -1);
    check("t1_c0", log_c[0], 30);
    check("t1_c1", log_c[1], 0);
    check("t1_c2", log_c[2], 2671);
    check("t1_c3", log_c[3], 3327);

    // T2 sub
    fill_rand();
    a_arr[0] = 5;   b_arr[0] = 7;
    a_arr[1] = 7;   b_arr[1] = 5;
    a_arr[2] = 0;   b_arr[2] = 0;
    a_arr[3] = 100; b_arr[3] = 0;
    a_arr[4] = 0;   b_arr[4] = 3328;
    run_frame(1, 100, 100, -1, -1, -1);
    check("t2_c0", log_c[0], 3327);
    check("t2_c1", log_c[1], 2);
    check("t2_c2", log_c[2], 0);
    check("t2_c3", log_c[3], 100);
    check("t2_c4", log_c[4], 1);
    check("t2_range_err", range_err_o, 0);

    // T3 backpressure, T4 framing with stray start
    fill_rand();
    run_frame(0, 100, 100, 100, -1, -1);
    fill_rand();
    run_frame($urandom_range(1), 80, 80, -1, 50, -1);

    // T5 range error then mid-frame reset
    fill_rand();
    a_arr[3] = 3329; b_arr[3] = 5;
    run_frame(0, 100, 100, -1, -1, -1);
    check("t5_range_err_held", range_err_o, 1);
    check("t5_oor_result", log_c[3], 5);
    fill_rand();
    run_frame(1, 90, 90, -1, -1, 100);
    fill_rand();
    run_frame(0, 100, 100, -1, -1, -1);
    check("t5_clean_range_err", range_err_o, 0);

    // T6 random stress
    for (int f = 0; f < 4; f++) begin
      fill_rand();
      run_frame($urandom_range(1), 60, 60, -1, -1, -1);
    end

    repeat (3) @(posedge clk);
    check("queue_empty", q_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
